cv4_column_filter: RTL and testbench

//  Single-input-channel sliding-window FP16 convolution engine. Input columns stream in one per

---
 rtl/cv4_column_filter.sv | 234 +++++++++++++++++++++++
 tb/tb_cv4_column_filter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv4_column_filter.sv
// Sliding-window FP16 column convolution: a KxK kernel store and a K-column window feed
// PARALLEL_UNITS dot products through a registered multiply stage and a registered adder tree.
module cv4_column_filter #(
  parameter int DATA_WIDTH = 16,
  parameter int KERNEL_SIZE = 4,
  parameter int INPUT_COL_SIZE = 5,
  localparam int PARALLEL_UNITS = INPUT_COL_SIZE - KERNEL_SIZE + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kernel_load,
  input  logic valid_in,
  input  logic [INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] input_column,
  input  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] kernel_column,
  output logic [PARALLEL_UNITS-1:0][DATA_WIDTH-1:0] output_column,
  output logic valid_out
);

  localparam int NP = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CW = $clog2(KERNEL_SIZE + 1);
  localparam logic [CW-1:0] FULL = CW'(KERNEL_SIZE);
  localparam logic [CW-1:0] LAST = CW'(KERNEL_SIZE - 1);

  // FP16 multiply, round-to-nearest-even, subnormals flushed to signed zero.
  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic s, az, bz, ai, bi, an, bn, g, st;
    logic [21:0] p;
    logic [10:0] mant;
    logic [7:0] eu;
    logic signed [7:0] e;
    logic [15:0] r;
    s  = a[15] ^ b[15];
    az = (a[14:10] == 5'd0);
    bz = (b[14:10] == 5'd0);
    ai = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    bi = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    an = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    bn = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    r = 16'h0000;
    if (an || bn || (ai && bz) || (bi && az)) begin
      r = 16'h7E00;
    end else if (ai || bi) begin
      r = {s, 5'h1F, 10'h000};
    end else if (az || bz) begin
      r = {s, 15'h0000};
    end else begin
      p  = {1'b1, a[9:0]} * {1'b1, b[9:0]};
      eu = {3'b000, a[14:10]} + {3'b000, b[14:10]} - 8'd15;
      e  = signed'(eu);
      if (p[21]) begin
        mant = p[21:11];
        g    = p[10];
        st   = |p[9:0];
        e    = e + 8'sd1;
      end else begin
        mant = p[20:10];
        g    = p[9];
        st   = |p[8:0];
      end
      if (g && (st || mant[0])) begin
        if (mant == 11'h7FF) begin
          mant = 11'h400;
          e    = e + 8'sd1;
        end else begin
          mant = mant + 11'd1;
        end
      end
      if (e <= 8'sd0) r = {s, 15'h0000};
      else if (e >= 8'sd31) r = {s, 5'h1F, 10'h000};
      else r = {s, e[4:0], mant[9:0]};
    end
    return r;
  endfunction

  // FP16 add with guard/round/sticky alignment; exact cancellation yields +0.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic az, bz, ai, bi, an, bn, sx, sy, g, rs;
    logic [4:0] ex, ey, d;
    logic [10:0] mx, my, mant;
    logic [29:0] ext;
    logic [13:0] xm, ym, n;
    logic [14:0] s;
    logic signed [7:0] e;
    logic [15:0] r;
    az = (a[14:10] == 5'd0);
    bz = (b[14:10] == 5'd0);
    ai = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    bi = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    an = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    bn = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    r = 16'h0000;
    if (an || bn) begin
      r = 16'h7E00;
    end else if (ai && bi) begin
      r = (a[15] != b[15]) ? 16'h7E00 : {a[15], 5'h1F, 10'h000};
    end else if (ai) begin
      r = {a[15], 5'h1F, 10'h000};
    end else if (bi) begin
      r = {b[15], 5'h1F, 10'h000};
    end else if (az && bz) begin
      r = {a[15] & b[15], 15'h0000};
    end else if (az) begin
      r = b;
    end else if (bz) begin
      r = a;
    end else begin
      if (a[14:0] >= b[14:0]) begin
        sx = a[15]; ex = a[14:10]; mx = {1'b1, a[9:0]};
        sy = b[15]; ey = b[14:10]; my = {1'b1, b[9:0]};
      end else begin
        sx = b[15]; ex = b[14:10]; mx = {1'b1, b[9:0]};
        sy = a[15]; ey = a[14:10]; my = {1'b1, a[9:0]};
      end
      d   = ex - ey;
      ext = {my, 19'h00000} >> d;
      ym  = ext[29:16] | {13'h0000, |ext[15:0]};
      xm  = {mx, 3'b000};
      e   = signed'({3'b000, ex});
      if (sx == sy) s = {1'b0, xm} + {1'b0, ym};
      else s = {1'b0, xm} - {1'b0, ym};
      if (s == 15'd0) begin
        r = 16'h0000;
      end else begin
        if (s[14]) begin
          n = s[14:1] | {13'h0000, s[0]};
          e = e + 8'sd1;
        end else begin
          n = s[13:0];
          for (int i = 0; i < 13; i++) begin
            if (!n[13]) begin
              n = n << 1;
              e = e - 8'sd1;
            end
          end
        end
        mant = n[13:3];
        g    = n[2];
        rs   = |n[1:0];
        if (g && (rs || mant[0])) begin
          if (mant == 11'h7FF) begin
            mant = 11'h400;
            e    = e + 8'sd1;
          end else begin
            mant = mant + 11'd1;
          end
        end
        if (e <= 8'sd0) r = {sx, 15'h0000};
        else if (e >= 8'sd31) r = {sx, 5'h1F, 10'h000};
        else r = {sx, e[4:0], mant[9:0]};
      end
    end
    return r;
  endfunction

  // Balanced pairwise reduction over adjacent product indices.
  function automatic logic [DATA_WIDTH-1:0] tree_sum(input logic [NP-1:0][DATA_WIDTH-1:0] p);
    logic [DATA_WIDTH-1:0] t [NP];
    int n;
    for (int i = 0; i < NP; i++) t[i] = p[i];
    n = NP;
    for (int lvl = 0; lvl < NP; lvl++) begin
      if (n > 1) begin
        for (int i = 0; i < NP / 2; i++) begin
          if (i < n / 2) t[i] = fp_add(t[2*i], t[2*i+1]);
        end
        if ((n % 2) == 1) t[n/2] = t[n-1];
        n = (n + 1) / 2;
      end
    end
    return t[0];
  endfunction

  logic [DATA_WIDTH-1:0] kcol [KERNEL_SIZE][KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] win [KERNEL_SIZE][INPUT_COL_SIZE];
  logic [CW-1:0] fill_cnt;
  logic issue, prod_valid, sum_valid;
  logic [NP-1:0][DATA_WIDTH-1:0] prod [PARALLEL_UNITS];
  logic [DATA_WIDTH-1:0] sums [PARALLEL_UNITS];

  assign issue = valid_in && !kernel_load && (fill_cnt >= LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kcol       <= '{default: '0};
      win        <= '{default: '0};
      fill_cnt   <= '0;
      prod_valid <= 1'b0;
    end else begin
      if (kernel_load) begin
        for (int c = 0; c < KERNEL_SIZE - 1; c++) kcol[c] <= kcol[c+1];
        for (int r = 0; r < KERNEL_SIZE; r++) kcol[KERNEL_SIZE-1][r] <= kernel_column[r];
        fill_cnt <= '0;
      end else if (valid_in) begin
        for (int c = 0; c < KERNEL_SIZE - 1; c++) win[c] <= win[c+1];
        for (int r = 0; r < INPUT_COL_SIZE; r++) win[KERNEL_SIZE-1][r] <= input_column[r];
        if (fill_cnt != FULL) fill_cnt <= fill_cnt + 1'b1;
      end
      prod_valid <= issue;
    end
  end

  // Products are indexed c*K+r so the adder tree pairs rows within a column first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod      <= '{default: '0};
      sum_valid <= 1'b0;
    end else begin
      if (prod_valid) begin
        for (int u = 0; u < PARALLEL_UNITS; u++)
          for (int c = 0; c < KERNEL_SIZE; c++)
            for (int r = 0; r < KERNEL_SIZE; r++)
              prod[u][c*KERNEL_SIZE+r] <= fp_mul(win[c][u+r], kcol[c][r]);
      end
      sum_valid <= prod_valid;
    end
  end

  always_comb begin
    for (int u = 0; u < PARALLEL_UNITS; u++) sums[u] = tree_sum(prod[u]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_column <= '0;
      valid_out     <= 1'b0;
    end else begin
      if (sum_valid) begin
        for (int u = 0; u < PARALLEL_UNITS; u++) output_column[u] <= sums[u];
      end
      valid_out <= sum_valid;
    end
  end

endmodule

// File: tb/tb_cv4_column_filter.sv
// Scoreboard bench for cv4_column_filter: a real-arithmetic FP16 reference predicts each
// output column and its arrival cycle; a monitor checks every cycle of the DUT output.
module tb_cv4_column_filter;

  localparam int K = 4;
  localparam int H = 5;
  localparam int PU = H - K + 1;

  typedef logic [H-1:0][15:0] col_t;
  typedef logic [K-1:0][15:0] kcol_t;
  typedef logic [PU-1:0][15:0] out_t;
  typedef struct {
    out_t col;
    int   due;
  } exp_t;

  logic clk, rst_n, kernel_load, valid_in, valid_out;
  col_t input_column;
  kcol_t kernel_column;
  out_t output_column;

  cv4_column_filter dut (
    .clk(clk),
    .rst_n(rst_n),
    .kernel_load(kernel_load),
    .valid_in(valid_in),
    .input_column(input_column),
    .kernel_column(kernel_column),
    .output_column(output_column),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t sb[$];
  out_t lastOut = '0;

  logic [15:0] mwin [K][H];
  logic [15:0] mk [K][K];
  int mcnt = 0;

  // ---------------- reference arithmetic on real numbers ----------------
  function automatic bit isNan(logic [15:0] h);
    return h[14:10] == 5'h1F && h[9:0] != 10'd0;
  endfunction
  function automatic bit isInf(logic [15:0] h);
    return h[14:10] == 5'h1F && h[9:0] == 10'd0;
  endfunction
  function automatic bit isZero(logic [15:0] h);
    return h[14:10] == 5'd0;
  endfunction

  function automatic real mag(logic [15:0] h);
    real m;
    int e;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return m;
  endfunction

  function automatic logic [15:0] toHalf(bit sgn, real m);
    int e;
    int fl;
    real s, sc, fr;
    logic [4:0] ef;
    logic [9:0] mf;
    e = 0;
    s = m;
    while (s >= 2.0) begin s = s / 2.0; e++; end
    while (s < 1.0) begin s = s * 2.0; e--; end
    sc = s * 1024.0;
    fl = $rtoi(sc);
    fr = sc - real'(fl);
    if (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) fl++;
    if (fl == 2048) begin fl = 1024; e++; end
    if (e < -14) return {sgn, 15'h0000};
    if (e > 15) return {sgn, 5'h1F, 10'h000};
    ef = 5'(e + 15);
    mf = 10'(fl - 1024);
    return {sgn, ef, mf};
  endfunction

  function automatic logic [15:0] refMul(logic [15:0] a, logic [15:0] b);
    bit sgn;
    sgn = a[15] ^ b[15];
    if (isNan(a) || isNan(b)) return 16'h7E00;
    if ((isInf(a) && isZero(b)) || (isInf(b) && isZero(a))) return 16'h7E00;
    if (isInf(a) || isInf(b)) return {sgn, 5'h1F, 10'h000};
    if (isZero(a) || isZero(b)) return {sgn, 15'h0000};
    return toHalf(sgn, mag(a) * mag(b));
  endfunction

  function automatic logic [15:0] refAdd(logic [15:0] a, logic [15:0] b);
    real va, vb, sum;
    if (isNan(a) || isNan(b)) return 16'h7E00;
    if (isInf(a) && isInf(b)) return (a[15] != b[15]) ? 16'h7E00 : a;
    if (isInf(a)) return a;
    if (isInf(b)) return b;
    if (isZero(a) && isZero(b)) return {a[15] & b[15], 15'h0000};
    if (isZero(a)) return b;
    if (isZero(b)) return a;
    va = a[15] ? -mag(a) : mag(a);
    vb = b[15] ? -mag(b) : mag(b);
    sum = va + vb;
    if (sum == 0.0) return 16'h0000;
    if (sum < 0.0) return toHalf(1'b1, -sum);
    return toHalf(1'b0, sum);
  endfunction

  function automatic out_t computeExpected();
    out_t res;
    logic [15:0] t [K*K];
    int n;
    for (int u = 0; u < PU; u++) begin
      for (int c = 0; c < K; c++)
        for (int r = 0; r < K; r++)
          t[c*K+r] = refMul(mwin[c][u+r], mk[c][r]);
      n = K * K;
      while (n > 1) begin
        for (int i = 0; i < n / 2; i++) t[i] = refAdd(t[2*i], t[2*i+1]);
        n = n / 2;
      end
      res[u] = t[0];
    end
    return res;
  endfunction

  // ---------------- stimulus and checking helpers ----------------
  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  task automatic applyStimulus(bit kl, bit vi, col_t col, kcol_t kc);
    @(negedge clk);
    kernel_load = kl;
    valid_in = vi;
    input_column = col;
    kernel_column = kc;
    if (kl) begin
      for (int c = 0; c < K - 1; c++) mk[c] = mk[c+1];
      for (int r = 0; r < K; r++) mk[K-1][r] = kc[r];
      mcnt = 0;
    end else if (vi) begin
      for (int c = 0; c < K - 1; c++) mwin[c] = mwin[c+1];
      for (int r = 0; r < H; r++) mwin[K-1][r] = col[r];
      if (mcnt < K) mcnt++;
      if (mcnt == K) sb.push_back('{col: computeExpected(), due: cyc + 3});
    end
  endtask

  task automatic resetModel();
    for (int c = 0; c < K; c++) begin
      for (int r = 0; r < H; r++) mwin[c][r] = 16'h0000;
      for (int r = 0; r < K; r++) mk[c][r] = 16'h0000;
    end
    mcnt = 0;
    sb.delete();
    lastOut = '0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    kernel_load = 1'b0;
    valid_in = 1'b0;
    resetModel();
    #1;
    checkOutput("reset_valid_out", 32'(valid_out), 32'd0);
    for (int u = 0; u < PU; u++) checkOutput("reset_output", 32'(output_column[u]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic col_t fillCol(logic [15:0] v);
    col_t c;
    for (int r = 0; r < H; r++) c[r] = v;
    return c;
  endfunction

  function automatic kcol_t fillKer(logic [15:0] v);
    kcol_t c;
    for (int r = 0; r < K; r++) c[r] = v;
    return c;
  endfunction

  function automatic logic [15:0] randHalf();
    int sel;
    sel = $urandom_range(0, 79);
    if (sel == 0) return {1'($urandom_range(0, 1)), 15'h7C00};
    if (sel == 1) return {1'($urandom_range(0, 1)), 15'h0000};
    if (sel == 2) return {1'($urandom_range(0, 1)), 5'd0, 10'($urandom_range(1, 1023))};
    return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 19)), 10'($urandom_range(0, 1023))};
  endfunction

  function automatic col_t randCol();
    col_t c;
    for (int r = 0; r < H; r++) c[r] = randHalf();
    return c;
  endfunction

  function automatic kcol_t randKer();
    kcol_t c;
    for (int r = 0; r < K; r++) c[r] = randHalf();
    return c;
  endfunction

  // ---------------- monitor: pops the scoreboard when the DUT presents a result ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid_out) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid at cycle %0d: got valid_out=1, expected 0", cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("latency", 32'(cyc), 32'(e.due));
          for (int u = 0; u < PU; u++) checkOutput($sformatf("out[%0d]", u), 32'(output_column[u]), 32'(e.col[u]));
        end
        lastOut = output_column;
      end else begin
        checkOutput("hold_output", 32'(output_column), 32'(lastOut));
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          checks++;
          errors++;
          $display("[TB] FAIL missing_valid at cycle %0d: got valid_out=0, expected 1", cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- directed scenarios followed by random traffic ----------------
  initial begin
    col_t col;
    kcol_t kz;
    kz = '0;
    rst_n = 1'b0;
    kernel_load = 1'b0;
    valid_in = 1'b0;
    input_column = '0;
    kernel_column = '0;
    resetModel();
    repeat (2) @(negedge clk);
    checkOutput("por_valid_out", 32'(valid_out), 32'd0);
    checkOutput("por_output", 32'(output_column), 32'd0);
    rst_n = 1'b1;

    $display("[TB] unity kernel");
    repeat (K) applyStimulus(1, 0, '0, fillKer(16'h3C00));
    repeat (K) applyStimulus(0, 1, fillCol(16'h3C00), kz);
    repeat (4) applyStimulus(0, 0, '0, kz);

    $display("[TB] streaming half kernel");
    repeat (K) applyStimulus(1, 0, '0, fillKer(16'h3800));
    repeat (6) applyStimulus(0, 1, fillCol(16'h4000), kz);
    repeat (4) applyStimulus(0, 0, '0, kz);

    $display("[TB] positional kernel");
    applyStimulus(1, 0, '0, {16'h0000, 16'h0000, 16'h0000, 16'h3C00});
    repeat (K - 1) applyStimulus(1, 0, '0, kz);
    for (int c = 0; c < 6; c++) begin
      for (int r = 0; r < H; r++) col[r] = {1'b0, 5'(c + 14), 10'(r * 64 + 3)};
      applyStimulus(0, 1, col, kz);
    end
    repeat (4) applyStimulus(0, 0, '0, kz);

    $display("[TB] specials and cancellation");
    repeat (K) applyStimulus(1, 0, '0, fillKer(16'h3C00));
    repeat (K - 1) applyStimulus(0, 1, fillCol(16'h3C00), kz);
    applyStimulus(0, 1, {16'h3C00, 16'h3C00, 16'h7C00, 16'h3C00, 16'h3C00}, kz);
    applyStimulus(0, 1, {16'h3C00, 16'hFC00, 16'h3C00, 16'h3C00, 16'h3C00}, kz);
    repeat (K) applyStimulus(0, 1, {16'h4500, 16'hC500, 16'h4500, 16'hC500, 16'h4500}, kz);
    repeat (4) applyStimulus(0, 0, '0, kz);

    $display("[TB] reload during streaming");
    repeat (5) applyStimulus(0, 1, randCol(), kz);
    repeat (K) applyStimulus(1, 1, randCol(), randKer());
    repeat (K + 3) applyStimulus(0, 1, randCol(), kz);
    repeat (4) applyStimulus(0, 0, '0, kz);

    $display("[TB] mid-stream reset");
    repeat (K) applyStimulus(1, 0, '0, randKer());
    repeat (K + 1) applyStimulus(0, 1, randCol(), kz);
    pulseReset();
    repeat (4) applyStimulus(0, 0, '0, kz);

    $display("[TB] random traffic");
    repeat (K) applyStimulus(1, 0, '0, randKer());
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 29) == 0) begin
        repeat (K) applyStimulus(1, 1'($urandom_range(0, 1)), randCol(), randKer());
      end
      applyStimulus(0, 1'($urandom_range(0, 3) != 0), randCol(), kz);
    end
    repeat (6) applyStimulus(0, 0, '0, kz);

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
